cic_decim_ctrl: RTL

//  Run-time sequencer for the CIC decimator datapath. Accepts a new decimation ratio on an
//  AXI-Stream-style config port, flushes the integrator/comb pipeline and generates the decimation strobe.

---
 rtl/cic_decim_ctrl_if.sv | 12 +
 rtl/cic_decim_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/cic_decim_ctrl_if.sv
// Rate-configuration stream for the CIC decimator sequencer.
// The master offers a decimation ratio; the slave accepts it with tready.
interface cic_decim_ctrl_if #(
  parameter int RATE_WIDTH = 6
);
  logic [RATE_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/cic_decim_ctrl.sv
// Run-time sequencer for the CIC decimator: flushes the integrator/comb chain on a ratio change,
// generates the keep-sample strobe and masks output until the combs hold valid history.
module cic_decim_ctrl #(
  parameter int CIC_R_MAX     = 32,
  parameter int CIC_R_DEFAULT = 4,
  parameter int CIC_N         = 3,
  parameter int FLUSH_CYCLES  = 4,
  parameter int RATE_WIDTH    = $clog2(CIC_R_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cic_decim_ctrl_if.slave       s_axis_rate,
  input  logic                  s_axis_in_tvalid,
  output logic                  dp_reset_n,
  output logic                  dp_decim_strobe,
  output logic                  out_enable,
  output logic                  busy,
  output logic                  rate_err,
  output logic [RATE_WIDTH-1:0] cur_rate
);

  localparam int DECIM_W  = (CIC_R_MAX > 1) ? $clog2(CIC_R_MAX) : 1;
  localparam int FLUSH_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int SETTLE_W = (CIC_N > 1) ? $clog2(CIC_N + 1) : 1;

  typedef enum logic [1:0] {
    FLUSH,
    SETTLE,
    RUN
  } state_t;

  state_t                state_q, state_d;
  logic [FLUSH_W-1:0]    flush_cnt, flush_d;
  logic [SETTLE_W-1:0]   settle_cnt, settle_d;
  logic [DECIM_W-1:0]    decim_cnt, decim_d;
  logic [RATE_WIDTH-1:0] rate_d;
  logic                  err_d;
  logic                  decim_last;
  logic                  rate_legal;

  assign decim_last = (RATE_WIDTH'(decim_cnt) == (cur_rate - RATE_WIDTH'(1)));
  assign rate_legal = (s_axis_rate.tdata != '0) &&
                      (s_axis_rate.tdata <= RATE_WIDTH'(CIC_R_MAX));

  assign dp_decim_strobe    = s_axis_in_tvalid & decim_last & (state_q != FLUSH);
  assign dp_reset_n         = (state_q != FLUSH);
  assign out_enable         = (state_q == RUN);
  assign busy               = (state_q != RUN);
  assign s_axis_rate.tready = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_cnt;
    settle_d = settle_cnt;
    decim_d  = decim_cnt;
    rate_d   = cur_rate;
    err_d    = 1'b0;

    if ((state_q != FLUSH) && s_axis_in_tvalid) begin
      decim_d = decim_last ? '0 : decim_cnt + DECIM_W'(1);
    end

    unique case (state_q)
      FLUSH: begin
        decim_d  = '0;
        settle_d = '0;
        if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
          state_d = SETTLE;
          flush_d = '0;
        end else begin
          flush_d = flush_cnt + FLUSH_W'(1);
        end
      end
      SETTLE: begin
        // Each strobe pushes one more sample of history into the combs.
        if (dp_decim_strobe) begin
          if (settle_cnt == SETTLE_W'(CIC_N - 1)) begin
            state_d  = RUN;
            settle_d = '0;
          end else begin
            settle_d = settle_cnt + SETTLE_W'(1);
          end
        end
      end
      RUN: begin
        // tready is high throughout RUN, so tvalid here is a completed transfer.
        if (s_axis_rate.tvalid) begin
          if (rate_legal) begin
            rate_d   = s_axis_rate.tdata;
            state_d  = FLUSH;
            flush_d  = '0;
            decim_d  = '0;
            settle_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= FLUSH;
      flush_cnt  <= '0;
      settle_cnt <= '0;
      decim_cnt  <= '0;
      cur_rate   <= RATE_WIDTH'(CIC_R_DEFAULT);
      rate_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_cnt  <= flush_d;
      settle_cnt <= settle_d;
      decim_cnt  <= decim_d;
      cur_rate   <= rate_d;
      rate_err   <= err_d;
    end
  end

endmodule
